// File: rtl/pc_branch_unit.sv
// Program-counter stage: sequential fetch, taken-branch redirect with a one-cycle
// wrong-path flush, link write for bl, and a sticky halt that only reset clears.
module pc_branch_unit #(
    parameter int unsigned          PC_WIDTH    = 32,
    parameter int unsigned          OFF_WIDTH   = 26,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
    parameter logic [5:0]           HALT_OPCODE = 6'b111111
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           OPCode,
    input  logic                 InstrValid,
    input  logic                 FlagOutput,
    input  logic [OFF_WIDTH-1:0] BranchOffset,
    input  logic [PC_WIDTH-1:0]  RegTarget,
    input  logic                 Stall,
    output logic [PC_WIDTH-1:0]  PC,
    output logic                 Flush,
    output logic                 LinkWe,
    output logic [PC_WIDTH-1:0]  LinkData,
    output logic                 Halted
);

    localparam logic [5:0] OP_BR = 6'b100000;
    localparam logic [5:0] OP_BL = 6'b101011;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        FLUSH = 2'b01,
        HALT  = 2'b10
    } state_t;

    state_t                state_r, state_s;
    logic [PC_WIDTH-1:0]   pc_r, pc_s;
    logic                  flush_r, flush_s;
    logic                  link_we_r, link_we_s;
    logic [PC_WIDTH-1:0]   link_data_r, link_data_s;
    logic                  halted_r, halted_s;

    logic [PC_WIDTH-1:0]   inc_s;
    logic [PC_WIDTH-1:0]   off_ext_s;
    logic [PC_WIDTH-1:0]   br_tgt_s;
    logic [PC_WIDTH-1:0]   reg_tgt_s;

    // Candidate next-PC values; all sums wrap modulo 2^PC_WIDTH.
    always_comb begin
        inc_s     = pc_r + PC_WIDTH'(4);
        off_ext_s = {{(PC_WIDTH-OFF_WIDTH){BranchOffset[OFF_WIDTH-1]}}, BranchOffset};
        br_tgt_s  = inc_s + (off_ext_s << 2);
        reg_tgt_s = RegTarget & {{(PC_WIDTH-2){1'b1}}, 2'b00};
    end

    // Next-state and next-output decision; Stall freezes everything except LinkWe.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        flush_s     = flush_r;
        link_we_s   = 1'b0;
        link_data_s = link_data_r;
        halted_s    = halted_r;
        case (state_r)
            RUN: begin
                if (Stall) begin
                    pc_s = pc_r;
                end else if (InstrValid && (OPCode == HALT_OPCODE)) begin
                    state_s  = HALT;
                    halted_s = 1'b1;
                    flush_s  = 1'b0;
                end else if (InstrValid && FlagOutput) begin
                    state_s = FLUSH;
                    flush_s = 1'b1;
                    if (OPCode == OP_BR) begin
                        pc_s = reg_tgt_s;
                    end else begin
                        pc_s = br_tgt_s;
                    end
                    if (OPCode == OP_BL) begin
                        link_we_s   = 1'b1;
                        link_data_s = inc_s;
                    end else begin
                        link_we_s   = 1'b0;
                    end
                end else begin
                    pc_s    = inc_s;
                    flush_s = 1'b0;
                end
            end
            FLUSH: begin
                // Decode slot is wrong-path here, so branch inputs are ignored.
                if (Stall) begin
                    pc_s = pc_r;
                end else begin
                    pc_s    = inc_s;
                    flush_s = 1'b0;
                    state_s = RUN;
                end
            end
            HALT: begin
                flush_s  = 1'b0;
                halted_s = 1'b1;
            end
            default: begin
                state_s  = RUN;
                pc_s     = RESET_PC;
                flush_s  = 1'b0;
                halted_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= RUN;
            pc_r        <= RESET_PC;
            flush_r     <= 1'b0;
            link_we_r   <= 1'b0;
            link_data_r <= '0;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            flush_r     <= flush_s;
            link_we_r   <= link_we_s;
            link_data_r <= link_data_s;
            halted_r    <= halted_s;
        end
    end

    assign PC       = pc_r;
    assign Flush    = flush_r;
    assign LinkWe   = link_we_r;
    assign LinkData = link_data_r;
    assign Halted   = halted_r;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: a driver issues directed vectors and queues the
// hand-computed outputs; a monitor pops and compares after every rising edge.
module tb_pc_branch_unit;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_B    = 6'b101000;
    localparam logic [5:0] OP_BL   = 6'b101011;
    localparam logic [5:0] OP_BR   = 6'b100000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    logic        clk;
    logic        rst;
    logic [5:0]  OPCode;
    logic        InstrValid;
    logic        FlagOutput;
    logic [25:0] BranchOffset;
    logic [31:0] RegTarget;
    logic        Stall;
    logic [31:0] PC;
    logic        Flush;
    logic        LinkWe;
    logic [31:0] LinkData;
    logic        Halted;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        flush;
        logic        lwe;
        logic [31:0] ld;
        logic        halted;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_id  = 0;

    pc_branch_unit dut (
        .clk(clk), .rst(rst), .OPCode(OPCode), .InstrValid(InstrValid),
        .FlagOutput(FlagOutput), .BranchOffset(BranchOffset), .RegTarget(RegTarget),
        .Stall(Stall), .PC(PC), .Flush(Flush), .LinkWe(LinkWe), .LinkData(LinkData),
        .Halted(Halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expectation per rising edge once the driver has queued one.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks += 5;
                if (PC !== e.pc) begin
                    failures++;
                    $display("FAIL pc step=%0d got=%h exp=%h", e.id, PC, e.pc);
                end
                if (Flush !== e.flush) begin
                    failures++;
                    $display("FAIL flush step=%0d got=%b exp=%b", e.id, Flush, e.flush);
                end
                if (LinkWe !== e.lwe) begin
                    failures++;
                    $display("FAIL linkwe step=%0d got=%b exp=%b", e.id, LinkWe, e.lwe);
                end
                if (LinkData !== e.ld) begin
                    failures++;
                    $display("FAIL linkdata step=%0d got=%h exp=%h", e.id, LinkData, e.ld);
                end
                if (Halted !== e.halted) begin
                    failures++;
                    $display("FAIL halted step=%0d got=%b exp=%b", e.id, Halted, e.halted);
                end
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic r, input logic [5:0] op, input logic iv,
                        input logic fl, input logic [25:0] off, input logic [31:0] rt,
                        input logic st, input logic [31:0] e_pc, input logic e_fl,
                        input logic e_lwe, input logic [31:0] e_ld, input logic e_h);
        exp_t e;
        @(negedge clk);
        rst = r; OPCode = op; InstrValid = iv; FlagOutput = fl;
        BranchOffset = off; RegTarget = rt; Stall = st;
        step_id++;
        e.id = step_id; e.pc = e_pc; e.flush = e_fl; e.lwe = e_lwe; e.ld = e_ld;
        e.halted = e_h;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b0; OPCode = OP_NOP; InstrValid = 1'b0; FlagOutput = 1'b0;
        BranchOffset = 26'h0; RegTarget = 32'h0; Stall = 1'b0;

        // T1: reset then sequential fetch
        step(1'b0, OP_NOP, 1'b1, 1'b0, 26'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, OP_NOP, 1'b1, 1'b1, 26'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, OP_NOP, 1'b1, 1'b0, 26'h0, 32'h0, 1'b0, 32'h4, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, OP_NOP, 1'b1, 1'b0, 26'h0, 32'h0, 1'b0, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, OP_NOP, 1'b1, 1'b0, 26'h0, 32'h0, 1'b0, 32'hC, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, OP_NOP, 1'b1, 1'b0, 26'h0, 32'h0, 1'b0, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0);
        // T2: taken b, offset -2, then wrong-path slot with a taken flag ignored
        step(1'b1, OP_B, 1'b1, 1'b1, 26'h3FF_FFFE, 32'h0, 1'b0, 32'hC, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, OP_B, 1'b1, 1'b1, 26'h3FF_FFFE, 32'h0, 1'b0, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, OP_NOP, 1'b1, 1'b0, 26'h0, 32'h0, 1'b0, 32'h14, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, OP_NOP, 1'b1, 1'b0, 26'h0, 32'h0, 1'b0, 32'h18, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, OP_NOP, 1'b1, 1'b0, 26'h0, 32'h0, 1'b0, 32'h1C, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, OP_NOP, 1'b1, 1'b0, 26'h0, 32'h0, 1'b0, 32'h20, 1'b0, 1'b0, 32'h0, 1'b0);
        // T3: bl +5 at 0x20, then br to 0x103, then a bubble carrying a taken flag
        step(1'b1, OP_BL, 1'b1, 1'b1, 26'h5, 32'h0, 1'b0, 32'h38, 1'b1, 1'b1, 32'h24, 1'b0);
        step(1'b1, OP_BL, 1'b1, 1'b1, 26'h5, 32'h0, 1'b0, 32'h3C, 1'b0, 1'b0, 32'h24, 1'b0);
        step(1'b1, OP_BR, 1'b1, 1'b1, 26'h0, 32'h103, 1'b0, 32'h100, 1'b1, 1'b0, 32'h24, 1'b0);
        step(1'b1, OP_NOP, 1'b1, 1'b0, 26'h0, 32'h0, 1'b0, 32'h104, 1'b0, 1'b0, 32'h24, 1'b0);
        step(1'b1, OP_BL, 1'b0, 1'b1, 26'h5, 32'h0, 1'b0, 32'h108, 1'b0, 1'b0, 32'h24, 1'b0);
        // T4: stall over a taken bl, then over its flush slot
        for (int i = 0; i < 3; i++)
            step(1'b1, OP_BL, 1'b1, 1'b1, 26'h1, 32'h0, 1'b1, 32'h108, 1'b0, 1'b0, 32'h24, 1'b0);
        step(1'b1, OP_BL, 1'b1, 1'b1, 26'h1, 32'h0, 1'b0, 32'h110, 1'b1, 1'b1, 32'h10C, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, OP_BL, 1'b1, 1'b1, 26'h1, 32'h0, 1'b1, 32'h110, 1'b1, 1'b0, 32'h10C, 1'b0);
        step(1'b1, OP_BL, 1'b1, 1'b1, 26'h1, 32'h0, 1'b0, 32'h114, 1'b0, 1'b0, 32'h10C, 1'b0);
        // T5: wrap-around via br to 0xFFFFFFF8, sequential wrap, and negative branch wrap
        step(1'b1, OP_BR, 1'b1, 1'b1, 26'h0, 32'hFFFF_FFFA, 1'b0, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h10C, 1'b0);
        step(1'b1, OP_NOP, 1'b1, 1'b0, 26'h0, 32'h0, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h10C, 1'b0);
        step(1'b1, OP_NOP, 1'b1, 1'b0, 26'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h10C, 1'b0);
        step(1'b1, OP_B, 1'b1, 1'b1, 26'h3FF_FFFE, 32'h0, 1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h10C, 1'b0);
        step(1'b1, OP_NOP, 1'b1, 1'b0, 26'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h10C, 1'b0);
        // Reset while in FLUSH (with Stall asserted)
        step(1'b1, OP_B, 1'b1, 1'b1, 26'h3, 32'h0, 1'b0, 32'h10, 1'b1, 1'b0, 32'h10C, 1'b0);
        step(1'b0, OP_B, 1'b1, 1'b1, 26'h3, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, OP_NOP, 1'b1, 1'b0, 26'h0, 32'h0, 1'b0, 32'h4, 1'b0, 1'b0, 32'h0, 1'b0);
        // Halt: stalled first, then taken, then frozen under any input
        step(1'b1, OP_HALT, 1'b1, 1'b1, 26'h7, 32'h0, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, OP_HALT, 1'b1, 1'b1, 26'h7, 32'h0, 1'b0, 32'h4, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, OP_BL, 1'b1, 1'b1, 26'h9, 32'h0, 1'b0, 32'h4, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, OP_BR, 1'b1, 1'b1, 26'h0, 32'h200, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, OP_NOP, 1'b1, 1'b0, 26'h0, 32'h0, 1'b0, 32'h4, 1'b0, 1'b0, 32'h0, 1'b1);
        // Reset out of HALT
        step(1'b0, OP_BL, 1'b1, 1'b1, 26'h9, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, OP_NOP, 1'b1, 1'b0, 26'h0, 32'h0, 1'b0, 32'h4, 1'b0, 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
